// File: rtl/mem_access_unit_pkg.sv
// Shared encodings and helpers for the load/store front end.
package mem_access_unit_pkg;

    typedef enum logic [1:0] {
        SZ_B = 2'd0,
        SZ_H = 2'd1,
        SZ_W = 2'd2,
        SZ_D = 2'd3
    } size_e;

    typedef enum logic [1:0] {
        EXC_NONE     = 2'd0,
        EXC_MISALIGN = 2'd1,
        EXC_ACCESS   = 2'd2
    } exc_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_READ  = 2'd1,
        ST_WRITE = 2'd2,
        ST_RESP  = 2'd3
    } state_e;

    function automatic logic [63:0] size_mask(size_e size);
        case (size)
            SZ_B:    return 64'h0000_0000_0000_00FF;
            SZ_H:    return 64'h0000_0000_0000_FFFF;
            SZ_W:    return 64'h0000_0000_FFFF_FFFF;
            default: return 64'hFFFF_FFFF_FFFF_FFFF;
        endcase
    endfunction

    // An access is aligned when the address is a multiple of its own size.
    function automatic logic is_misaligned(size_e size, logic [2:0] offset);
        case (size)
            SZ_H:    return offset[0] != 1'b0;
            SZ_W:    return offset[1:0] != 2'b00;
            SZ_D:    return offset != 3'b000;
            default: return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/mem_access_unit_byte_lane_align.sv
// Combinational little-endian lane extraction for loads and lane merge for stores.
module byte_lane_align
    import mem_access_unit_pkg::*;
(
    input  logic [63:0] word,
    input  logic [2:0]  offset,
    input  size_e       size,
    input  logic        is_unsigned,
    input  logic [63:0] wdata,
    output logic [63:0] load_value,
    output logic [63:0] store_word
);

    logic [5:0]  shamt;
    logic [63:0] shifted;
    logic [63:0] lane_mask;

    assign shamt = {offset, 3'b000};

    always_comb begin
        // NOTE: every output gets a default before the case so no latch is inferred.
        shifted    = word >> shamt;
        lane_mask  = size_mask(size) << shamt;
        store_word = (word & ~lane_mask) | ((wdata & size_mask(size)) << shamt);
        load_value = shifted;
        case (size)
            SZ_B: load_value = {{56{shifted[7]  & ~is_unsigned}}, shifted[7:0]};
            SZ_H: load_value = {{48{shifted[15] & ~is_unsigned}}, shifted[15:0]};
            SZ_W: load_value = {{32{shifted[31] & ~is_unsigned}}, shifted[31:0]};
            default: load_value = shifted;
        endcase
    end

endmodule

// File: rtl/mem_access_unit.sv
// Load/store front end: turns sized requests into aligned 64-bit data_bus cycles.
module mem_access_unit
    import mem_access_unit_pkg::*;
#(
    parameter int BUS_ALIGN = 3
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_store,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    input  logic [63:0] req_addr,
    input  logic [63:0] req_wdata,
    output logic        resp_valid,
    output logic [63:0] resp_rdata,
    output logic [1:0]  resp_exc,
    output logic        bus_rw,
    output logic [63:0] bus_addr,
    output logic [63:0] bus_write,
    input  logic [63:0] bus_read,
    input  logic        bus_exception
);

    state_e      state;
    logic        lat_store;
    size_e       lat_size;
    logic        lat_unsigned;
    logic [2:0]  lat_offset;
    logic [63:0] lat_wdata;
    logic [63:0] load_value;
    logic [63:0] store_word;
    size_e       in_size;

    assign in_size = size_e'(req_size);

    byte_lane_align u_align (
        .word        (bus_read),
        .offset      (lat_offset),
        .size        (lat_size),
        .is_unsigned (lat_unsigned),
        .wdata       (lat_wdata),
        .load_value  (load_value),
        .store_word  (store_word)
    );

    // NOTE: all state is updated with non-blocking assignments so every register sees pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= ST_IDLE;
            req_ready    <= 1'b1;
            resp_valid   <= 1'b0;
            resp_rdata   <= '0;
            resp_exc     <= EXC_NONE;
            bus_rw       <= 1'b0;
            bus_addr     <= '0;
            bus_write    <= '0;
            lat_store    <= 1'b0;
            lat_size     <= SZ_B;
            lat_unsigned <= 1'b0;
            lat_offset   <= '0;
            lat_wdata    <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (req_valid) begin
                        req_ready    <= 1'b0;
                        lat_store    <= req_store;
                        lat_size     <= in_size;
                        lat_unsigned <= req_unsigned;
                        lat_offset   <= req_addr[2:0];
                        lat_wdata    <= req_wdata;
                        if (is_misaligned(in_size, req_addr[2:0])) begin
                            state      <= ST_RESP;
                            resp_valid <= 1'b1;
                            resp_exc   <= EXC_MISALIGN;
                            resp_rdata <= '0;
                        end else begin
                            bus_addr <= {req_addr[63:BUS_ALIGN], {BUS_ALIGN{1'b0}}};
                            if (req_store && in_size == SZ_D) begin
                                state     <= ST_WRITE;
                                bus_write <= req_wdata;
                                bus_rw    <= 1'b1;
                            end else begin
                                state <= ST_READ;
                            end
                        end
                    end
                end
                ST_READ: begin
                    if (bus_exception) begin
                        state      <= ST_RESP;
                        resp_valid <= 1'b1;
                        resp_exc   <= EXC_ACCESS;
                        resp_rdata <= '0;
                    end else if (!lat_store) begin
                        state      <= ST_RESP;
                        resp_valid <= 1'b1;
                        resp_exc   <= EXC_NONE;
                        resp_rdata <= load_value;
                    end else begin
                        state     <= ST_WRITE;
                        bus_write <= store_word;
                        bus_rw    <= 1'b1;
                    end
                end
                ST_WRITE: begin
                    state      <= ST_RESP;
                    bus_rw     <= 1'b0;
                    bus_write  <= '0;
                    resp_valid <= 1'b1;
                    resp_rdata <= '0;
                    resp_exc   <= bus_exception ? EXC_ACCESS : EXC_NONE;
                end
                default: begin
                    state      <= ST_IDLE;
                    resp_valid <= 1'b0;
                    req_ready  <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit with a byte-level reference model and per-cycle comparison.
module tb_mem_access_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic        req_store;
    logic [1:0]  req_size;
    logic        req_unsigned;
    logic [63:0] req_addr;
    logic [63:0] req_wdata;
    logic        resp_valid;
    logic [63:0] resp_rdata;
    logic [1:0]  resp_exc;
    logic        bus_rw;
    logic [63:0] bus_addr;
    logic [63:0] bus_write;
    logic [63:0] bus_read;
    logic        bus_exception;

    always #5 clk = ~clk;

    mem_access_unit #(.BUS_ALIGN(3)) dut (
        .clk           (clk),
        .rst           (rst),
        .req_valid     (req_valid),
        .req_ready     (req_ready),
        .req_store     (req_store),
        .req_size      (req_size),
        .req_unsigned  (req_unsigned),
        .req_addr      (req_addr),
        .req_wdata     (req_wdata),
        .resp_valid    (resp_valid),
        .resp_rdata    (resp_rdata),
        .resp_exc      (resp_exc),
        .bus_rw        (bus_rw),
        .bus_addr      (bus_addr),
        .bus_write     (bus_write),
        .bus_read      (bus_read),
        .bus_exception (bus_exception)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Expected transaction timeline, relative to the accept edge (cycle 1 = first cycle after it).
    logic        active = 1'b0;
    int          k;
    int          exp_lat;
    int          exp_wcyc;
    logic [63:0] exp_rdata;
    logic [63:0] exp_bw;
    logic [63:0] exp_addr;
    logic [1:0]  exp_exc;
    logic [63:0] last_addr = 64'h0;
    logic [63:0] got_rdata;
    logic [63:0] got_bw;
    logic [1:0]  got_exc;

    always @(negedge clk) begin
        if (active) begin
            k++;
            check("bus_rw", {63'h0, bus_rw}, {63'h0, k == exp_wcyc});
            check("resp_valid", {63'h0, resp_valid}, {63'h0, k == exp_lat});
            check("req_ready_busy", {63'h0, req_ready}, 64'h0);
            check("bus_addr", bus_addr, exp_addr);
            if (k == exp_wcyc) begin
                check("bus_write", bus_write, exp_bw);
                got_bw = bus_write;
            end
            if (k == exp_lat) begin
                check("resp_rdata", resp_rdata, exp_rdata);
                check("resp_exc", {62'h0, resp_exc}, {62'h0, exp_exc});
                got_rdata = resp_rdata;
                got_exc   = resp_exc;
                active    = 1'b0;
            end
        end
    end

    // Byte-level model of what a request must produce.
    task automatic model(input logic st, input logic [1:0] sz, input logic un,
                         input logic [63:0] a, input logic [63:0] wd,
                         input logic [63:0] rd, input logic bex);
        int n;
        int off;
        logic [63:0] val;
        n   = 1 << sz;
        off = int'(a[2:0]);
        exp_rdata = 64'h0;
        exp_bw    = 64'h0;
        exp_wcyc  = 0;
        if ((off % n) != 0) begin
            exp_lat  = 1;
            exp_exc  = 2'd1;
            exp_addr = last_addr;
            return;
        end
        exp_addr  = a - 64'(off);
        last_addr = exp_addr;
        if (!st) begin
            exp_lat = 2;
            if (bex) begin
                exp_exc = 2'd2;
            end else begin
                exp_exc = 2'd0;
                val = 64'h0;
                for (int i = 0; i < n; i++) val[8*i +: 8] = rd[8*(off+i) +: 8];
                if (!un && n < 8 && val[8*n-1])
                    for (int i = n; i < 8; i++) val[8*i +: 8] = 8'hFF;
                exp_rdata = val;
            end
        end else if (n == 8) begin
            exp_wcyc = 1;
            exp_lat  = 2;
            exp_bw   = wd;
            exp_exc  = bex ? 2'd2 : 2'd0;
        end else if (bex) begin
            exp_lat = 2;
            exp_exc = 2'd2;
        end else begin
            exp_wcyc = 2;
            exp_lat  = 3;
            exp_exc  = 2'd0;
            exp_bw   = rd;
            for (int i = 0; i < n; i++) exp_bw[8*(off+i) +: 8] = wd[8*i +: 8];
        end
    endtask

    task automatic do_req(input logic st, input logic [1:0] sz, input logic un,
                          input logic [63:0] a, input logic [63:0] wd,
                          input logic [63:0] rd, input logic bex);
        model(st, sz, un, a, wd, rd, bex);
        @(posedge clk);
        #1;
        check("idle_ready", {63'h0, req_ready}, 64'h1);
        req_store     = st;
        req_size      = sz;
        req_unsigned  = un;
        req_addr      = a;
        req_wdata     = wd;
        bus_read      = rd;
        bus_exception = bex;
        req_valid     = 1'b1;
        @(posedge clk);
        k      = 0;
        active = 1'b1;
        #1;
        // Scramble the request fields to show the unit works from latched copies.
        req_valid    = 1'b0;
        req_addr     = 64'hFFFF_FFFF_FFFF_FFFF;
        req_wdata    = 64'hA5A5_A5A5_A5A5_A5A5;
        req_size     = 2'd0;
        req_store    = ~st;
        req_unsigned = ~un;
        for (int i = 0; i < 10 && active; i++) @(posedge clk);
        if (active) begin
            check("resp_timeout", 64'h0, 64'h1);
            active = 1'b0;
        end
        bus_exception = 1'b0;
    endtask

    initial begin
        rst           = 1'b1;
        req_valid     = 1'b0;
        req_store     = 1'b0;
        req_size      = 2'd0;
        req_unsigned  = 1'b0;
        req_addr      = 64'h0;
        req_wdata     = 64'h0;
        bus_read      = 64'h0;
        bus_exception = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_req_ready", {63'h0, req_ready}, 64'h1);
        check("rst_resp_valid", {63'h0, resp_valid}, 64'h0);
        check("rst_resp_rdata", resp_rdata, 64'h0);
        check("rst_resp_exc", {62'h0, resp_exc}, 64'h0);
        check("rst_bus_rw", {63'h0, bus_rw}, 64'h0);
        check("rst_bus_addr", bus_addr, 64'h0);
        check("rst_bus_write", bus_write, 64'h0);
        rst = 1'b0;

        // Signed and unsigned byte loads of 0x80.
        do_req(1'b0, 2'd0, 1'b0, 64'h1003, 64'h0, 64'h0000_0000_8000_0000, 1'b0);
        check("pin_lb_signed", got_rdata, 64'hFFFF_FFFF_FFFF_FF80);
        do_req(1'b0, 2'd0, 1'b1, 64'h1003, 64'h0, 64'h0000_0000_8000_0000, 1'b0);
        check("pin_lb_unsigned", got_rdata, 64'h0000_0000_0000_0080);

        // Half store read-modify-write into the top lanes.
        do_req(1'b1, 2'd1, 1'b0, 64'h1006, 64'h0000_0000_0000_BEEF, 64'h1122_3344_5566_7788, 1'b0);
        check("pin_sh_merge", got_bw, 64'hBEEF_3344_5566_7788);

        // Doubleword store goes straight to WRITE.
        do_req(1'b1, 2'd3, 1'b0, 64'h1008, 64'hDEAD_BEEF_0000_0001, 64'h0, 1'b0);
        check("pin_sd_exc", {62'h0, got_exc}, 64'h0);

        // Misaligned word load leaves the bus untouched.
        do_req(1'b0, 2'd2, 1'b0, 64'h1002, 64'h0, 64'h0, 1'b0);
        check("pin_misalign_exc", {62'h0, got_exc}, 64'h1);

        // Access faults on a load READ and on a byte-store READ.
        do_req(1'b0, 2'd3, 1'b0, 64'h2000, 64'h0, 64'h1234_5678_9ABC_DEF0, 1'b1);
        check("pin_load_fault", {62'h0, got_exc}, 64'h2);
        do_req(1'b1, 2'd0, 1'b0, 64'h2005, 64'h77, 64'h1122_3344_5566_7788, 1'b1);

        // Assorted sizes, offsets and signs.
        do_req(1'b0, 2'd2, 1'b0, 64'h3004, 64'h0, 64'h8765_4321_0000_0000, 1'b0);
        do_req(1'b0, 2'd2, 1'b1, 64'h3004, 64'h0, 64'h8765_4321_0000_0000, 1'b0);
        do_req(1'b0, 2'd1, 1'b0, 64'h3002, 64'h0, 64'h0000_0000_7FFF_0000, 1'b0);
        do_req(1'b0, 2'd3, 1'b0, 64'h3008, 64'h0, 64'hCAFE_F00D_1234_5678, 1'b0);
        do_req(1'b1, 2'd2, 1'b0, 64'h4004, 64'hFFFF_FFFF_0BAD_F00D, 64'h1111_2222_3333_4444, 1'b0);
        do_req(1'b1, 2'd0, 1'b0, 64'h4000, 64'h0000_0000_0000_01AB, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0);
        do_req(1'b1, 2'd3, 1'b0, 64'h4010, 64'h0102_0304_0506_0708, 64'h0, 1'b1);
        do_req(1'b1, 2'd1, 1'b0, 64'h4011, 64'hFFFF, 64'h0, 1'b0);
        do_req(1'b0, 2'd3, 1'b0, 64'h4014, 64'h0, 64'h0, 1'b0);

        // Reset during WRITE of a half store aborts with no response.
        @(posedge clk);
        #1;
        req_store    = 1'b1;
        req_size     = 2'd1;
        req_unsigned = 1'b0;
        req_addr     = 64'h1006;
        req_wdata    = 64'hBEEF;
        bus_read     = 64'h1122_3344_5566_7788;
        req_valid    = 1'b1;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("rst_write_pre_rw", {63'h0, bus_rw}, 64'h1);
        rst = 1'b1;
        @(negedge clk);
        check("abort_bus_rw", {63'h0, bus_rw}, 64'h0);
        check("abort_req_ready", {63'h0, req_ready}, 64'h1);
        check("abort_resp_valid", {63'h0, resp_valid}, 64'h0);
        check("abort_bus_write", bus_write, 64'h0);
        rst = 1'b0;
        last_addr = 64'h0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("abort_no_resp", {63'h0, resp_valid}, 64'h0);
        end

        // Unit must be fully usable after the abort.
        do_req(1'b0, 2'd1, 1'b1, 64'h5006, 64'h0, 64'h8001_0000_0000_0000, 1'b0);
        check("pin_after_abort", got_rdata, 64'h0000_0000_0000_8001);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/mem_access_unit.md
# mem_access_unit

Load/store front end sitting directly upstream of `data_bus`. It accepts one memory request at a time from the execute stage and converts byte, half, word or doubleword accesses into aligned 64-bit `data_bus` cycles. Sub-doubleword stores become a read-modify-write. Load data is returned extended to 64 bits. Misalignment and bus range exceptions are reported on a single-entry response channel.

## Interface
- `BUS_ALIGN`, default 3: log2 of bus word bytes; bus address low `BUS_ALIGN` bits are always zero.
- `clk`  in  1  sole clock.
- `rst`  in  1  synchronous, active-high reset.
- `req_valid`  in  1  request present.
- `req_ready`  out  1  unit idle; request accepted when `req_valid & req_ready`.
- `req_store`  in  1  1 = store, 0 = load.
- `req_size`  in  2  0 byte, 1 half, 2 word, 3 doubleword.
- `req_unsigned`  in  1  loads: zero-extend; otherwise sign-extend.
- `req_addr`  in  64  byte address.
- `req_wdata`  in  64  store data, right-aligned.
- `resp_valid`  out  1  one-cycle pulse, response complete.
- `resp_rdata`  out  64  extended load data; 0 for stores and on exception.
- `resp_exc`  out  2  0 none, 1 misaligned, 2 access fault.
- `bus_rw`  out  1  `data_bus` `rw`; 1 only in WRITE state.
- `bus_addr`  out  64  `data_bus` `addr`, doubleword-aligned, registered.
- `bus_write`  out  64  `data_bus` `write`, registered.
- `bus_read`  in  64  `data_bus` `read`, combinational, same cycle.
- `bus_exception`  in  1  `data_bus` `exception`, combinational, same cycle.

## Operation
- States: IDLE, READ, WRITE, RESP.
- IDLE: `req_ready`=1. On accept, latch store, size, unsigned flag, byte offset `addr[2:0]` and data. Set `bus_addr` = `req_addr & ~7`.
- Misaligned check on accept: `addr[size-1:0] != 0` for size > 0. On misalignment, go to RESP with exc=1. No bus cycle is issued and `bus_addr` is not updated.
- Load or sub-doubleword store: IDLE -> READ.
  - In READ, sample `bus_read` and `bus_exception` at the clock edge.
  - Exception: go to RESP with exc=2.
  - Load: extract `bus_read >> (offset*8)`, mask to size, extend, then go to RESP.
  - Store: merge the masked `req_wdata << (offset*8)` into the read word, load `bus_write`, then go to WRITE.
- Doubleword store: IDLE -> WRITE directly, with `bus_write` = `req_wdata`.
- WRITE: `bus_rw`=1 for exactly one cycle.
  - If `bus_exception`=1 that cycle, exc=2.
  - Exit to RESP. `bus_write` is then cleared to 0.
- RESP: `resp_valid`=1 for one cycle, then return to IDLE.
- Byte lanes: little-endian; byte k of the bus word is bits `[8k+7:8k]`.
- `bus_addr` holds its last value outside a transaction. `data_bus` peripherals decode on address change, so the address must never glitch while `bus_rw`=1.
- `bus_rw` stays 0 in IDLE, READ and RESP.

## Timing
- Reset values: state IDLE, `req_ready` 1, `resp_valid` 0, `resp_rdata` 0, `resp_exc` 0, `bus_rw` 0, `bus_addr` 0, `bus_write` 0.
- Accept-to-`resp_valid` latency:
  - Misaligned: 1 cycle.
  - Load: 2 cycles.
  - Doubleword store: 2 cycles.
  - Sub-doubleword store: 3 cycles.
- `req_ready` is 0 from the cycle after accept through the RESP cycle, so there are no back-to-back accepts. The next accept is possible in the cycle after RESP.
- Reset during any state aborts the request with no response. `bus_rw` is 0 in the next cycle.
- `req_valid` deasserting after accept has no effect, because all fields are latched.

## Structure
- Shared package holds:
  - Size encodings: `SZ_B`, `SZ_H`, `SZ_W`, `SZ_D`.
  - Exception codes: `EXC_NONE`, `EXC_MISALIGN`, `EXC_ACCESS`.
  - State encodings.
- Extract/merge logic is a sub-module `byte_lane_align`. It is combinational and takes word, offset, size, unsigned flag and store data. It outputs the extended load value and the merged store word.

## Test plan
- Load byte signed: `addr`=0x1003 with `bus_read`=0x0000_0000_8000_0000 (byte 3 = 0x80) -> `bus_addr` 0x1000, `resp_rdata` 0xFFFF_FFFF_FFFF_FF80 two cycles after accept. The same access with unsigned set -> 0x80.
- Half store: `addr`=0x1006, data 0xBEEF, `bus_read`=0x1122_3344_5566_7788 -> exactly one `bus_rw`=1 cycle with `bus_write`=0xBEEF_3344_5566_7788; `resp_valid` three cycles after accept.
- Doubleword store: 0x1008 with data 0xDEAD_BEEF_0000_0001 -> no READ cycle, `bus_rw`=1 in the cycle after accept, `resp_exc`=0.
- Misaligned word load at 0x1002 -> `resp_exc`=1 the cycle after accept, `bus_rw` never 1, `bus_addr` unchanged.
- `bus_exception`=1 during READ of a load -> `resp_exc`=2, `resp_rdata`=0. During the READ of a byte store -> `resp_exc`=2 and no WRITE cycle.
- Assert `rst` in WRITE of a half store -> next cycle `bus_rw`=0, `req_ready`=1, no `resp_valid`.
